id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on posedge clk.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have inputs in_valid (1), rs1_data (32), rs2_data (32), imm (32), alu_op (2), funct3 (3), funct7_5 (1), alu_src (1: 0=rs2, 1=imm), is_branch (1), rd (5), reg_write (1): decoded instruction from ID.
REQ-004 SHALL have input stall (1), freezing all state and outputs; input flush (1), discarding the current instruction.
REQ-005 SHALL have output in_ready (1), accept permission to ID.
REQ-006 SHALL have outputs A (32), B (32), ALU_control (4), all registered, driving the ALU inputs.
REQ-007 SHALL have outputs out_valid (1), out_rd (5), out_reg_write (1), all registered.
REQ-008 SHALL have input Zero (1) from the ALU, and outputs branch_valid (1) and branch_taken (1), both registered.

Function
REQ-009 SHALL accept an instruction on posedge when in_valid && in_ready && !stall && !flush; outputs update on that same edge (1-cycle latency); out_valid=1 for that cycle only unless stalled.
REQ-010 SHALL drive A=rs1_data and B=(alu_src ? imm : rs2_data).
REQ-011 SHALL encode ALU_control: alu_op 00 -> 0010 (ADD); 01 -> 0110 (SUB); 10 -> funct3 000: funct7_5 ? 0110 : 0010; funct3 111 -> 0000; funct3 110 -> 0001; other funct3 -> 1111; alu_op 11 -> 1111 (pass A).
REQ-012 SHALL force ALU_control=0110 for accepted branches regardless of alu_op.
REQ-013 SHALL implement FSM RUN, BR_EXEC, BR_RESOLVE; RUN: branch accepted -> BR_EXEC; BR_EXEC -> BR_RESOLVE; BR_RESOLVE -> RUN.
REQ-014 SHALL hold in_ready=1 only in RUN; 0 in BR_EXEC and BR_RESOLVE (ALU result is one cycle behind its inputs).
REQ-015 SHALL, on the BR_RESOLVE->RUN edge, set branch_valid=1 and branch_taken = (funct3==000 ? Zero : ~Zero) using the captured branch funct3; both SHALL be 0 in every other cycle.
REQ-016 SHALL treat only funct3 000 (beq) and 001 (bne) as branches; other funct3 with is_branch resolve as not-taken.
REQ-017 SHALL, when in_valid=0 or in_ready=0 in RUN, clear out_valid and out_reg_write while holding A/B/ALU_control.
REQ-018 SHALL, with stall=1, hold state, FSM and all outputs, including branch_valid; branch_valid SHALL NOT repeat after stall release.
REQ-019 SHALL, with flush=1 (priority over stall and acceptance), clear out_valid, out_reg_write, branch_valid, branch_taken, return to RUN, discard any pending branch.
REQ-020 SHALL keep out_reg_write=0 for branches.

Reset
REQ-021 SHALL on rst: FSM=RUN, A=B=0, ALU_control=0000, out_rd=0, out_valid=out_reg_write=branch_valid=branch_taken=0; in_ready=1 from the next cycle.
REQ-022 SHALL give rst priority over flush, stall and acceptance; rst in BR_EXEC/BR_RESOLVE SHALL produce no branch_valid.

Structure
REQ-023 SHALL place the ALU_control encodings (AND 0000, OR 0001, ADD 0010, SUB 0110, PASS 1111), alu_op codes and FSM state encodings in shared package riscv_pkg.
REQ-024 SHALL isolate the REQ-011/012 decode in combinational sub-module alu_ctrl_decode; the FSM and registers stay in id_ex_stage.

Verification
REQ-025 SHALL verify R-type add: rs1=5, rs2=7, alu_op=10, funct3=000, funct7_5=0 -> next cycle A=5, B=7, ALU_control=0010, out_valid=1.
REQ-026 SHALL verify I-type OR: alu_src=1, imm=0xF0, funct3=110 -> B=0xF0, ALU_control=0001.
REQ-027 SHALL verify beq rs1=rs2=9 with ALU attached -> in_ready low 2 cycles; branch_valid=1, branch_taken=1 exactly once, 3 cycles after acceptance.
REQ-028 SHALL verify bne rs1=3, rs2=4 -> branch_taken=1; beq on same operands -> branch_taken=0.
REQ-029 SHALL verify flush in BR_EXEC -> no branch_valid, in_ready=1 next cycle.
REQ-030 SHALL verify stall 3 cycles with out_valid=1 -> outputs frozen; after release a new instruction is accepted in the first unstalled cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the ID/EX stage: ALU control codes, alu_op codes,
// funct3 values of interest and the branch-sequencing FSM states.
package riscv_pkg;
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_PASS = 4'b1111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_PASS  = 2'b11;

   localparam logic [2:0] F3_ADDSUB = 3'b000;
   localparam logic [2:0] F3_OR     = 3'b110;
   localparam logic [2:0] F3_AND    = 3'b111;
   localparam logic [2:0] F3_BEQ    = 3'b000;
   localparam logic [2:0] F3_BNE    = 3'b001;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_BR_EXEC    = 2'd1,
      ST_BR_RESOLVE = 2'd2
   } state_t;
endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode from alu_op/funct3/funct7_5.
// Branches always compare by subtraction so the ALU Zero flag is meaningful.
module alu_ctrl_decode
   import riscv_pkg::*;
(
   input  logic [1:0] i_alu_op,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7_5,
   input  logic       i_is_branch,
   output logic [3:0] o_alu_ctrl
);
   always_comb begin
      o_alu_ctrl = ALU_PASS;
      if (i_is_branch) begin
         o_alu_ctrl = ALU_SUB;
      end else begin
         case (i_alu_op)
            ALUOP_ADD:   o_alu_ctrl = ALU_ADD;
            ALUOP_SUB:   o_alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
               case (i_funct3)
                  F3_ADDSUB: o_alu_ctrl = i_funct7_5 ? ALU_SUB : ALU_ADD;
                  F3_AND:    o_alu_ctrl = ALU_AND;
                  F3_OR:     o_alu_ctrl = ALU_OR;
                  default:   o_alu_ctrl = ALU_PASS;
               endcase
            end
            default:     o_alu_ctrl = ALU_PASS;
         endcase
      end
   end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with branch sequencing: a branch blocks new input
// for two cycles so the ALU Zero flag (one cycle behind its inputs) can resolve it.
module id_ex_stage
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic [31:0] imm,
   input  logic [1:0]  alu_op,
   input  logic [2:0]  funct3,
   input  logic        funct7_5,
   input  logic        alu_src,
   input  logic        is_branch,
   input  logic [4:0]  rd,
   input  logic        reg_write,
   input  logic        stall,
   input  logic        flush,
   input  logic        Zero,
   output logic        in_ready,
   output logic [31:0] A,
   output logic [31:0] B,
   output logic [3:0]  ALU_control,
   output logic        out_valid,
   output logic [4:0]  out_rd,
   output logic        out_reg_write,
   output logic        branch_valid,
   output logic        branch_taken
);
   state_t      r_state;
   logic [31:0] r_a, r_b;
   logic [3:0]  r_ctrl;
   logic [4:0]  r_rd;
   logic        r_valid, r_reg_write, r_br_valid, r_br_taken;
   logic [2:0]  r_br_f3;

   logic        w_accept;
   logic        w_taken;
   logic [3:0]  w_ctrl;

   alu_ctrl_decode u_dec (
      .i_alu_op    (alu_op),
      .i_funct3    (funct3),
      .i_funct7_5  (funct7_5),
      .i_is_branch (is_branch),
      .o_alu_ctrl  (w_ctrl)
   );

   assign in_ready = (r_state == ST_RUN);
   assign w_accept = in_valid & in_ready & ~stall & ~flush;
   // Only beq/bne can be taken; any other funct3 tagged as a branch falls through.
   assign w_taken  = (r_br_f3 == F3_BEQ) ? Zero :
                     (r_br_f3 == F3_BNE) ? ~Zero : 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_RUN;
         r_a         <= '0;
         r_b         <= '0;
         r_ctrl      <= ALU_AND;
         r_rd        <= '0;
         r_valid     <= 1'b0;
         r_reg_write <= 1'b0;
         r_br_valid  <= 1'b0;
         r_br_taken  <= 1'b0;
         r_br_f3     <= '0;
      end else if (flush) begin
         r_state     <= ST_RUN;
         r_valid     <= 1'b0;
         r_reg_write <= 1'b0;
         r_br_valid  <= 1'b0;
         r_br_taken  <= 1'b0;
      end else if (!stall) begin
         r_valid     <= w_accept;
         r_reg_write <= w_accept & reg_write & ~is_branch;
         r_br_valid  <= 1'b0;
         r_br_taken  <= 1'b0;
         if (w_accept) begin
            r_a    <= rs1_data;
            r_b    <= alu_src ? imm : rs2_data;
            r_ctrl <= w_ctrl;
            r_rd   <= rd;
         end
         case (r_state)
            ST_RUN: begin
               if (w_accept && is_branch) begin
                  r_state <= ST_BR_EXEC;
                  r_br_f3 <= funct3;
               end
            end
            ST_BR_EXEC:    r_state <= ST_BR_RESOLVE;
            ST_BR_RESOLVE: begin
               r_state    <= ST_RUN;
               r_br_valid <= 1'b1;
               r_br_taken <= w_taken;
            end
            default:       r_state <= ST_RUN;
         endcase
      end
   end

   assign A             = r_a;
   assign B             = r_b;
   assign ALU_control   = r_ctrl;
   assign out_valid     = r_valid;
   assign out_rd        = r_rd;
   assign out_reg_write = r_reg_write;
   assign branch_valid  = r_br_valid;
   assign branch_taken  = r_br_taken;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver predicts each accepted instruction
// and branch outcome into queues; a negedge monitor pops and compares.
module tb_id_ex_stage;
   logic        clk = 1'b0;
   logic        rst, in_valid, funct7_5, alu_src, is_branch, reg_write, stall, flush;
   logic [31:0] rs1_data, rs2_data, imm;
   logic [1:0]  alu_op;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic        in_ready, out_valid, out_reg_write, branch_valid, branch_taken;
   logic [31:0] A, B;
   logic [3:0]  ALU_control;
   logic [4:0]  out_rd;
   logic        r_zero = 1'b0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .imm(imm), .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .alu_src(alu_src),
      .is_branch(is_branch), .rd(rd), .reg_write(reg_write), .stall(stall), .flush(flush),
      .Zero(r_zero), .in_ready(in_ready), .A(A), .B(B), .ALU_control(ALU_control),
      .out_valid(out_valid), .out_rd(out_rd), .out_reg_write(out_reg_write),
      .branch_valid(branch_valid), .branch_taken(branch_taken)
   );

   // Attached ALU with a registered Zero flag.
   function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
      case (c)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         default: return a;
      endcase
   endfunction
   always @(posedge clk) r_zero <= (alu(A, B, ALU_control) == 32'd0);

   typedef struct {
      logic [31:0] a, b;
      logic [3:0]  ctrl;
      logic [4:0]  rd;
      logic        rw;
   } exp_t;
   exp_t exp_q[$];
   logic br_q[$];
   int   vectors = 0, errors = 0;
   int   busy = 0;         // 0: ready, 1/2: cycles spent waiting on a branch
   bit   br_pending = 0;
   bit   started = 0;
   logic e_rst, e_flush, e_stall;
   logic [76:0] snap;
   wire  [76:0] cur = {A, B, ALU_control, out_rd, out_valid, out_reg_write, branch_valid, branch_taken};

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [2:0] f3,
                                           input logic f75, input logic br);
      if (br) return 4'b0110;
      case (op)
         2'b00: return 4'b0010;
         2'b01: return 4'b0110;
         2'b11: return 4'b1111;
         default: begin
            if (f3 == 3'b000) return f75 ? 4'b0110 : 4'b0010;
            if (f3 == 3'b111) return 4'b0000;
            if (f3 == 3'b110) return 4'b0001;
            return 4'b1111;
         end
      endcase
   endfunction

   // Apply current inputs for one clock, predicting what the stage must produce.
   task automatic step();
      bit   acc;
      exp_t e;
      logic d;
      acc = in_valid && busy == 0 && !stall && !flush && !rst;
      if (acc) begin
         e.a = rs1_data; e.b = alu_src ? imm : rs2_data;
         e.ctrl = ref_ctrl(alu_op, funct3, funct7_5, is_branch);
         e.rd = rd; e.rw = reg_write && !is_branch;
         exp_q.push_back(e);
         if (is_branch)
            br_q.push_back(funct3 == 3'b000 ? (rs1_data == rs2_data) :
                           funct3 == 3'b001 ? (rs1_data != rs2_data) : 1'b0);
      end
      @(posedge clk); #1;
      if (rst || flush) begin
         if (br_pending) begin d = br_q.pop_back(); br_pending = 0; end
         busy = 0;
      end else if (!stall) begin
         if (busy == 2) begin busy = 0; br_pending = 0; end
         else if (busy == 1) busy = 2;
         else if (acc && is_branch) begin busy = 1; br_pending = 1; end
      end
   endtask

   task automatic idle();
      in_valid = 0; step();
   endtask

   task automatic issue(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                        input logic [1:0] op, input logic [2:0] f3, input logic f75,
                        input logic src, input logic br, input logic [4:0] d, input logic rw);
      in_valid = 1; rs1_data = r1; rs2_data = r2; imm = im; alu_op = op; funct3 = f3;
      funct7_5 = f75; alu_src = src; is_branch = br; rd = d; reg_write = rw;
      step();
   endtask

   task automatic run_branch(input logic [31:0] r1, input logic [31:0] r2,
                             input logic [2:0] f3, input logic exp_taken);
      issue(r1, r2, 0, 2'b01, f3, 0, 0, 1, 5'd0, 0);
      chk("br_ready_low1", in_ready, 0);
      idle();
      chk("br_ready_low2", in_ready, 0);
      chk("br_early_valid", branch_valid, 0);
      idle();
      chk("br_valid_at3", branch_valid, 1);
      chk("br_taken_at3", branch_taken, exp_taken);
      chk("br_ready_back", in_ready, 1);
      idle();
      chk("br_valid_once", branch_valid, 0);
   endtask

   always @(posedge clk) begin
      e_rst   <= rst;
      e_flush <= flush;
      e_stall <= stall;
   end

   always @(negedge clk) begin
      exp_t e;
      logic t;
      if (started) begin
         chk("in_ready", in_ready, busy == 0);
         if (e_rst) begin
            chk("reset_outputs", cur, 77'd0);
         end else if (e_stall && !e_flush) begin
            chk("stall_freeze", cur, snap);
         end else begin
            if (out_valid) begin
               if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("out_fields", {A, B, ALU_control, out_rd, out_reg_write},
                      {e.a, e.b, e.ctrl, e.rd, e.rw});
               end
            end else chk("idle_reg_write", out_reg_write, 0);
            if (branch_valid) begin
               if (br_q.size() == 0) chk("unexpected_branch_valid", 1, 0);
               else begin
                  t = br_q.pop_front();
                  chk("branch_taken", branch_taken, t);
               end
            end else chk("taken_without_valid", branch_taken, 0);
         end
      end
      snap = cur;
   end

   initial begin
      rst = 1; flush = 0; stall = 0; in_valid = 0; rs1_data = 0; rs2_data = 0; imm = 0;
      alu_op = 0; funct3 = 0; funct7_5 = 0; alu_src = 0; is_branch = 0; rd = 0; reg_write = 0;
      step();
      started = 1;
      step();
      rst = 0;
      idle();

      // R-type add, I-type OR, sub variant
      issue(5, 7, 0, 2'b10, 3'b000, 0, 0, 0, 5'd3, 1);
      chk("radd_A", A, 5); chk("radd_B", B, 7); chk("radd_ctrl", ALU_control, 4'b0010);
      chk("radd_valid", out_valid, 1);
      issue(1, 2, 32'hF0, 2'b10, 3'b110, 0, 1, 0, 5'd4, 1);
      chk("ior_B", B, 32'hF0); chk("ior_ctrl", ALU_control, 4'b0001);
      issue(9, 4, 0, 2'b10, 3'b000, 1, 0, 0, 5'd5, 1);
      idle();
      chk("valid_one_cycle", out_valid, 0);

      // branches
      run_branch(9, 9, 3'b000, 1);
      run_branch(3, 4, 3'b001, 1);
      run_branch(3, 4, 3'b000, 0);
      run_branch(7, 8, 3'b100, 0);

      // flush while in BR_EXEC
      issue(9, 9, 0, 2'b01, 3'b000, 0, 0, 1, 5'd0, 0);
      in_valid = 0; flush = 1; step(); flush = 0;
      chk("flush_ready", in_ready, 1);
      chk("flush_no_bv", branch_valid, 0);
      idle(); idle();
      chk("flush_no_late_bv", branch_valid, 0);

      // stall with out_valid high, then accept on first free cycle
      issue(11, 12, 0, 2'b00, 3'b000, 0, 0, 0, 5'd7, 1);
      stall = 1;
      for (int i = 0; i < 3; i++) issue(99, 98, 0, 2'b01, 3'b000, 0, 0, 0, 5'd9, 1);
      chk("stall_hold_valid", out_valid, 1);
      chk("stall_hold_A", A, 11);
      stall = 0;
      issue(21, 22, 0, 2'b00, 3'b000, 0, 0, 0, 5'd8, 1);
      chk("release_accept_A", A, 21);
      chk("release_accept_rd", out_rd, 8);

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         rst       = ($urandom % 100) == 0;
         flush     = ($urandom % 25) == 0;
         stall     = ($urandom % 6) == 0;
         in_valid  = ($urandom % 4) != 0;
         rs1_data  = $urandom;
         rs2_data  = ($urandom % 3 == 0) ? rs1_data : $urandom;
         imm       = $urandom;
         alu_op    = 2'($urandom);
         funct3    = 3'($urandom);
         funct7_5  = 1'($urandom);
         is_branch = ($urandom % 5) == 0;
         alu_src   = is_branch ? 1'b0 : 1'($urandom);
         if (is_branch && ($urandom % 4 != 0)) funct3 = 3'($urandom % 2);
         rd        = 5'($urandom);
         reg_write = 1'($urandom);
         step();
      end
      rst = 0; flush = 0; stall = 0;
      for (int i = 0; i < 4; i++) idle();
      chk("out_queue_drained", exp_q.size(), 0);
      chk("branch_queue_drained", br_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
